// File: rtl/scmp_uart_pkg.sv
// Shared definitions for the SC/MP bus UART.
// Register offsets, register bit positions and FSM state types.
package scmp_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_READY = 1;
  localparam int ST_OVERRUN  = 2;
  localparam int ST_FRAME    = 3;
  localparam int ST_TX_IDLE  = 4;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/scmp_uart_fifo.sv
// Small synchronous FIFO for received bytes.
// A push into a full FIFO is accepted only when a pop frees a slot in the same clk.
module scmp_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scmp_bus_uart.sv
// SC/MP bus target UART: DATA/STATUS/CTRL registers,
// 16x oversampled 8N1 receiver with FIFO, transmitter with one holding byte.
module scmp_bus_uart
  import scmp_uart_pkg::*;
#(
  parameter int          CLK_HZ   = 4_000_000,
  parameter int          BAUD     = 2400,
  parameter logic [15:0] BASE     = 16'hFD00,
  parameter int          RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ADS_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic [11:0] addr,
  input  logic [7:0]  D_i,
  output logic [7:0]  D_o,
  output logic        D_oe,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        irq
);

  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(RX_DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [3:0] bank;
  logic       sel;
  logic       rd_prev;
  logic       wr_prev;
  logic       rd_done;
  logic       wr_fall;
  logic [1:0] ra;
  logic [1:0] ctrl;
  logic [7:0] status;
  logic [7:0] rd_mux;
  logic       overrun;
  logic       frame_err;
  logic       ovr_set;
  logic       fe_set;
  logic       st_clr;
  logic       rx_avail;
  logic       tx_ready;
  logic       tx_idle;

  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [AW:0]   fifo_count;

  logic       hold_valid;
  logic [7:0] hold_data;
  logic       hold_acc;

  tx_state_t  tx_state;
  tx_state_t  tx_state_n;
  logic [DW-1:0] tx_div;
  logic       tx_tick;
  logic [3:0] tx_tcnt;
  logic [3:0] tx_tcnt_n;
  logic [2:0] tx_bit;
  logic [2:0] tx_bit_n;
  logic [7:0] tx_shift;
  logic [7:0] tx_shift_n;
  logic       tx_load;
  logic       ser_tx_n;

  rx_state_t  rx_state;
  rx_state_t  rx_state_n;
  logic       rx_meta;
  logic       rx_sync;
  logic       rx_prev;
  logic       rx_fall;
  logic [DW-1:0] rx_div;
  logic [DW-1:0] rx_div_n;
  logic       rx_tick;
  logic [3:0] rx_tcnt;
  logic [3:0] rx_tcnt_n;
  logic [2:0] rx_bit;
  logic [2:0] rx_bit_n;
  logic [7:0] rx_shift;
  logic [7:0] rx_shift_n;
  logic       rx_push;

  assign ra      = addr[1:0];
  assign sel     = ({bank, addr[11:2]} == BASE[15:2]);
  assign rd_done = sel & ~rd_prev & RD_n;
  assign wr_fall = sel & wr_prev & ~WR_n;

  assign rx_avail = (fifo_count != '0);
  assign tx_ready = ~hold_valid;
  assign tx_idle  = (tx_state == TX_IDLE);
  assign fifo_pop = rd_done & (ra == REG_DATA);
  assign st_clr   = rd_done & (ra == REG_STATUS);
  assign ovr_set  = rx_push & fifo_full & ~fifo_pop;

  // A byte written while the holding reg drains into the shifter is kept.
  assign hold_acc = wr_fall & (ra == REG_DATA) & (~hold_valid | tx_load);

  always_comb begin
    status = '0;
    status[ST_RX_AVAIL] = rx_avail;
    status[ST_TX_READY] = tx_ready;
    status[ST_OVERRUN]  = overrun;
    status[ST_FRAME]    = frame_err;
    status[ST_TX_IDLE]  = tx_idle;
  end

  always_comb begin
    rd_mux = '0;
    unique case (ra)
      REG_DATA:   rd_mux = fifo_empty ? 8'h00 : fifo_rdata;
      REG_STATUS: rd_mux = status;
      REG_CTRL:   rd_mux = {6'b0, ctrl};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank      <= '0;
      rd_prev   <= 1'b1;
      wr_prev   <= 1'b1;
      D_o       <= '0;
      D_oe      <= 1'b0;
      ctrl      <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (!ADS_n) begin
        bank <= D_i[3:0];
      end
      rd_prev <= RD_n;
      wr_prev <= WR_n;
      if (!RD_n && sel) begin
        D_o  <= rd_mux;
        D_oe <= 1'b1;
      end else begin
        D_oe <= 1'b0;
      end
      if (wr_fall && ra == REG_CTRL) begin
        ctrl <= D_i[1:0];
      end
      overrun   <= ovr_set | (overrun & ~st_clr);
      frame_err <= fe_set | (frame_err & ~st_clr);
      irq <= (ctrl[CTRL_RX_IE] & rx_avail)
           | (ctrl[CTRL_TX_IE] & tx_ready);
    end
  end

  scmp_uart_fifo #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (fifo_pop),
    .wdata (rx_shift),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_tick = (tx_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      tx_div     <= '0;
      tx_state   <= TX_IDLE;
      tx_tcnt    <= '0;
      tx_bit     <= '0;
      tx_shift   <= '0;
      ser_tx     <= 1'b1;
    end else begin
      if (hold_acc) begin
        hold_valid <= 1'b1;
        hold_data  <= D_i;
      end else if (tx_load) begin
        hold_valid <= 1'b0;
      end
      tx_div   <= tx_tick ? '0 : tx_div + 1'b1;
      tx_state <= tx_state_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      ser_tx   <= ser_tx_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_load    = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (hold_valid) begin
          tx_load    = 1'b1;
          tx_shift_n = hold_data;
          tx_tcnt_n  = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_tcnt_n = tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            tx_bit_n   = '0;
            tx_state_n = TX_DATA;
          end
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_tcnt_n = tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_bit_n   = tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              tx_state_n = TX_STOP;
            end
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_tcnt_n = tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (hold_valid) begin
              tx_load    = 1'b1;
              tx_shift_n = hold_data;
              tx_state_n = TX_START;
            end else begin
              tx_state_n = TX_IDLE;
            end
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    unique case (tx_state_n)
      TX_START: ser_tx_n = 1'b0;
      TX_DATA:  ser_tx_n = tx_shift_n[0];
      default:  ser_tx_n = 1'b1;
    endcase
  end

  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_tick = (rx_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_div   <= '0;
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_meta  <= ser_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_div   <= rx_div_n;
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_tcnt_n  = rx_tcnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_div_n   = rx_tick ? '0 : rx_div + 1'b1;
    rx_push    = 1'b0;
    fe_set     = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_div_n   = '0;
          rx_tcnt_n  = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_tcnt_n = rx_tcnt + 4'd1;
          // Mid start bit: a high line here was only a glitch.
          if (rx_tcnt == 4'd7) begin
            rx_tcnt_n  = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_tcnt_n = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shift_n = {rx_sync, rx_shift[7:1]};
            rx_bit_n   = rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
              rx_state_n = RX_STOP;
            end
          end
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_tcnt_n = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_push    = rx_sync;
            fe_set     = ~rx_sync;
            rx_state_n = RX_IDLE;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_scmp_bus_uart.sv
// Scoreboard bench for scmp_bus_uart: bus reads/writes,
// serial frames in both directions, overrun, frame error, irq, reset.
module tb_scmp_bus_uart;

  localparam int CLK_HZ = 384_000;
  localparam int BAUD   = 2400;
  localparam int DIV    = CLK_HZ / (BAUD * 16);
  localparam int BIT    = 16 * DIV;
  localparam int OFF    = BIT / 2 - DIV / 2;
  localparam int DEPTH  = 4;
  localparam logic [11:0] A_DATA = 12'hD00;
  localparam logic [11:0] A_STAT = 12'hD01;
  localparam logic [11:0] A_CTRL = 12'hD02;

  typedef struct {
    logic [7:0] data;
    logic       start;
    logic       stop;
    int         lowlen;
    int         t0;
  } frame_t;

  logic        clk;
  logic        rst_n;
  logic        ADS_n;
  logic        RD_n;
  logic        WR_n;
  logic [11:0] addr;
  logic [7:0]  D_i;
  logic [7:0]  D_o;
  logic        D_oe;
  logic        ser_rx;
  logic        ser_tx;
  logic        irq;

  int checks;
  int errors;
  int cyc;
  logic mon_en;
  frame_t mon_q[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  logic ovr_m;
  logic fe_m;

  scmp_bus_uart #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .BASE     (16'hFD00),
    .RX_DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ADS_n  (ADS_n),
    .RD_n   (RD_n),
    .WR_n   (WR_n),
    .addr   (addr),
    .D_i    (D_i),
    .D_o    (D_o),
    .D_oe   (D_oe),
    .ser_rx (ser_rx),
    .ser_tx (ser_tx),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame decoder on ser_tx: samples each bit near its centre.
  initial begin
    frame_t f;
    int rise;
    int k;
    forever begin
      @(negedge ser_tx);
      if (mon_en) begin
        f.data = '0;
        f.start = 1'b1;
        f.stop = 1'b0;
        f.t0 = 0;
        rise = 0;
        for (int c = 1; c <= 9 * BIT + OFF; c++) begin
          @(negedge clk);
          if (c == 1) f.t0 = cyc;
          if (rise == 0 && ser_tx === 1'b1) rise = c;
          if (c >= OFF && (c - OFF) % BIT == 0) begin
            k = (c - OFF) / BIT;
            if (k == 0) f.start = ser_tx;
            else if (k < 9) f.data[k-1] = ser_tx;
            else f.stop = ser_tx;
          end
        end
        f.lowlen = rise - 1;
        if (mon_en) mon_q.push_back(f);
      end
    end
  end

  function automatic logic [7:0] exp_status(input logic txr,
                                            input logic txi);
    return {3'b000, txi, fe_m, ovr_m, txr, rx_exp.size() > 0};
  endfunction

  function automatic logic [7:0] pop_rx();
    if (rx_exp.size() == 0) return 8'h00;
    return rx_exp.pop_front();
  endfunction

  task automatic set_bank(input logic [3:0] b);
    @(negedge clk);
    ADS_n = 1'b0;
    D_i = {4'h0, b};
    @(negedge clk);
    ADS_n = 1'b1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    D_i = d;
    WR_n = 1'b0;
    repeat (2) @(negedge clk);
    WR_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [11:0] a, input int hold,
                          output logic [7:0] d, output logic oe);
    @(negedge clk);
    addr = a;
    RD_n = 1'b0;
    repeat (hold) @(negedge clk);
    d = D_o;
    oe = D_oe;
    RD_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    ser_rx = stop_ok;
    repeat (BIT) @(negedge clk);
    ser_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    if (!stop_ok) fe_m = 1'b1;
    else if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
    else ovr_m = 1'b1;
  endtask

  task automatic wait_frames(input int n, output logic ok);
    int k;
    k = 0;
    while (mon_q.size() < n && k < 25 * BIT) begin
      @(negedge clk);
      k++;
    end
    ok = (mon_q.size() >= n);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic oe;
    rst_n = 1'b0;
    ADS_n = 1'b1;
    RD_n = 1'b1;
    WR_n = 1'b1;
    addr = '0;
    D_i = '0;
    ser_rx = 1'b1;
    mon_en = 1'b0;
    ovr_m = 1'b0;
    fe_m = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ser_tx !== 1'b1 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_lines ser_tx=%b irq=%b want 1 0", ser_tx, irq);
    end
    checks++;
    if (D_oe !== 1'b0 || D_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus D_oe=%b D_o=%h want 0 00", D_oe, D_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    set_bank(4'hF);
    bus_read(A_STAT, 2, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1) || oe !== 1'b1) begin
      errors++;
      $display("FAIL reset_status got %h oe=%b want %h oe=1",
               d, oe, exp_status(1'b1, 1'b1));
    end
  endtask

  task automatic test_tx();
    frame_t f;
    logic ok;
    logic [7:0] d;
    logic oe;
    logic [7:0] e;
    mon_q.delete();
    mon_en = 1'b1;
    tx_exp.push_back(8'h55);
    bus_write(A_DATA, 8'h55);
    wait_frames(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL tx_timeout frames=%0d want 1", mon_q.size());
    end else begin
      f = mon_q.pop_front();
      e = tx_exp.pop_front();
      checks++;
      if (f.data !== e || f.start !== 1'b0 || f.stop !== 1'b1) begin
        errors++;
        $display("FAIL tx_frame got %h st=%b sp=%b want %h 0 1",
                 f.data, f.start, f.stop, e);
      end
      checks++;
      if (f.lowlen < BIT - DIV + 1 || f.lowlen > BIT) begin
        errors++;
        $display("FAIL tx_start_len got %0d want %0d..%0d",
                 f.lowlen, BIT - DIV + 1, BIT);
      end
    end
    repeat (BIT) @(negedge clk);
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1)) begin
      errors++;
      $display("FAIL tx_idle_status got %h want %h",
               d, exp_status(1'b1, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    frame_t f1;
    frame_t f2;
    logic ok;
    logic [7:0] d;
    logic oe;
    logic [7:0] e1;
    logic [7:0] e2;
    int gap;
    mon_q.delete();
    tx_exp.push_back(8'h3A);
    tx_exp.push_back(8'h81);
    bus_write(A_DATA, 8'h3A);
    bus_write(A_DATA, 8'h81);
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b0, 1'b0)) begin
      errors++;
      $display("FAIL b2b_busy_status got %h want %h",
               d, exp_status(1'b0, 1'b0));
    end
    bus_write(A_DATA, 8'h7E);
    wait_frames(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_timeout frames=%0d want 2", mon_q.size());
    end else begin
      f1 = mon_q.pop_front();
      f2 = mon_q.pop_front();
      e1 = tx_exp.pop_front();
      e2 = tx_exp.pop_front();
      checks++;
      if (f1.data !== e1 || f2.data !== e2 || f2.stop !== 1'b1) begin
        errors++;
        $display("FAIL b2b_data got %h %h want %h %h",
                 f1.data, f2.data, e1, e2);
      end
      gap = f2.t0 - f1.t0;
      checks++;
      if (gap < 10 * BIT - DIV + 1 || gap > 10 * BIT) begin
        errors++;
        $display("FAIL b2b_gap got %0d want %0d..%0d",
                 gap, 10 * BIT - DIV + 1, 10 * BIT);
      end
      checks++;
      if (f2.lowlen != BIT) begin
        errors++;
        $display("FAIL b2b_start2_len got %0d want %0d", f2.lowlen, BIT);
      end
    end
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (mon_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_dropped extra_frames=%0d want 0", mon_q.size());
    end
  endtask

  task automatic test_rx();
    logic [7:0] d;
    logic [7:0] e;
    logic oe;
    send_byte(8'hA5, 1'b1);
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1)) begin
      errors++;
      $display("FAIL rx_avail got %h want %h", d, exp_status(1'b1, 1'b1));
    end
    bus_read(A_DATA, 1, d, oe);
    e = pop_rx();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL rx_data got %h want %h", d, e);
    end
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1)) begin
      errors++;
      $display("FAIL rx_popped got %h want %h", d, exp_status(1'b1, 1'b1));
    end
  endtask

  task automatic test_overrun();
    logic [7:0] d;
    logic [7:0] e;
    logic oe;
    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(A_DATA, 1, d, oe);
      e = pop_rx();
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL ovr_read%0d got %h want %h", i, d, e);
      end
    end
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1)) begin
      errors++;
      $display("FAIL ovr_status got %h want %h", d, exp_status(1'b1, 1'b1));
    end
    ovr_m = 1'b0;
    fe_m = 1'b0;
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1)) begin
      errors++;
      $display("FAIL ovr_cleared got %h want %h",
               d, exp_status(1'b1, 1'b1));
    end
  endtask

  task automatic test_frame_err();
    logic [7:0] d;
    logic oe;
    send_byte(8'hF0, 1'b0);
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1)) begin
      errors++;
      $display("FAIL fe_status got %h want %h", d, exp_status(1'b1, 1'b1));
    end
    ovr_m = 1'b0;
    fe_m = 1'b0;
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1)) begin
      errors++;
      $display("FAIL fe_cleared got %h want %h", d, exp_status(1'b1, 1'b1));
    end
  endtask

  task automatic test_irq_decode();
    logic [7:0] d;
    logic [7:0] e;
    logic oe;
    bus_write(A_CTRL, 8'hFD);
    bus_read(A_CTRL, 1, d, oe);
    checks++;
    if (d !== 8'h01 || irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_ctrl got %h irq=%b want 01 0", d, irq);
    end
    send_byte(8'h3C, 1'b1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rx got %b want 1", irq);
    end
    bus_read(A_DATA, 1, d, oe);
    e = pop_rx();
    repeat (2) @(negedge clk);
    checks++;
    if (d !== e || irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_pop got %h irq=%b want %h 0", d, irq, e);
    end
    bus_write(A_CTRL, 8'h02);
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_tx got %b want 1", irq);
    end
    set_bank(4'hE);
    bus_write(A_CTRL, 8'h00);
    bus_write(A_DATA, 8'h77);
    bus_read(A_CTRL, 2, d, oe);
    checks++;
    if (oe !== 1'b0 || ser_tx !== 1'b1) begin
      errors++;
      $display("FAIL decode_bankE oe=%b ser_tx=%b want 0 1", oe, ser_tx);
    end
    set_bank(4'hF);
    bus_read(A_CTRL, 1, d, oe);
    checks++;
    if (d !== 8'h02 || irq !== 1'b1) begin
      errors++;
      $display("FAIL decode_ctrl got %h irq=%b want 02 1", d, irq);
    end
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1)) begin
      errors++;
      $display("FAIL decode_tx got %h want %h", d, exp_status(1'b1, 1'b1));
    end
    bus_write(A_CTRL, 8'h00);
  endtask

  task automatic test_rd_hold();
    logic [7:0] d;
    logic [7:0] e;
    logic oe;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus_read(A_DATA, (i == 0) ? 6 : 1, d, oe);
      e = pop_rx();
      checks++;
      if (d !== e || oe !== 1'b1) begin
        errors++;
        $display("FAIL rdhold_%0d got %h oe=%b want %h 1", i, d, oe, e);
      end
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    logic [7:0] e;
    logic oe;
    int k;
    mon_en = 1'b0;
    send_byte(8'h99, 1'b1);
    bus_write(A_DATA, 8'h00);
    k = 0;
    while (ser_tx !== 1'b0 && k < 4 * DIV) begin
      @(negedge clk);
      k++;
    end
    repeat (3 * DIV) @(negedge clk);
    checks++;
    if (ser_tx !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_tx ser_tx=%b want 0", ser_tx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ser_tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_async ser_tx=%b want 1", ser_tx);
    end
    rx_exp.delete();
    tx_exp.delete();
    ovr_m = 1'b0;
    fe_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_bank(4'hF);
    bus_read(A_STAT, 1, d, oe);
    checks++;
    if (d !== exp_status(1'b1, 1'b1) || ser_tx !== 1'b1) begin
      errors++;
      $display("FAIL rst_status got %h tx=%b want %h 1",
               d, ser_tx, exp_status(1'b1, 1'b1));
    end
    bus_read(A_DATA, 1, d, oe);
    e = pop_rx();
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL rst_fifo got %h want %h", d, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx();
    test_overrun();
    test_frame_err();
    test_irq_decode();
    test_rd_hold();
    test_reset_mid_tx();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
